// File: rtl/fifo_rd_stream.sv
// Read-side streaming engine: issues FIFO reads, absorbs the 1-cycle memory
// latency in a 2-entry buffer and presents a valid/ready stream with burst markers.
module fifo_rd_stream #(
    parameter int DSIZE = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [DSIZE-1:0] fifo_rdata,
    output logic             fifo_rinc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_last,
    output logic [7:0]       beat_cnt
);

    localparam logic [7:0] LAST_BEAT = 8'(BURST - 1);

    logic             pend_r;
    logic [1:0]       held_r;
    logic [DSIZE-1:0] buf0_r;
    logic [DSIZE-1:0] buf1_r;
    logic [7:0]       beat_cnt_r;

    logic             pop_s;
    logic [1:0]       total_s;
    logic             rinc_s;
    logic [1:0]       held_nxt_s;
    logic [DSIZE-1:0] buf0_nxt_s;
    logic [DSIZE-1:0] buf1_nxt_s;
    logic [7:0]       beat_nxt_s;

    assign m_valid   = (held_r != 2'd0);
    assign m_data    = buf0_r;
    assign m_last    = m_valid && (beat_cnt_r == LAST_BEAT);
    assign beat_cnt  = beat_cnt_r;
    assign fifo_rinc = rinc_s;
    assign pop_s     = m_valid && m_ready;
    assign total_s   = held_r + {1'b0, pend_r};

    // Read request: a slot is free now, or the full buffer is popping this cycle.
    always_comb begin
        rinc_s = 1'b0;
        if (rst_n && en && !fifo_empty &&
            ((total_s < 2'd2) || ((total_s == 2'd2) && pop_s))) begin
            rinc_s = 1'b1;
        end else begin
            rinc_s = 1'b0;
        end
    end

    // Buffer steering: capture the returning word and/or shift on a pop.
    always_comb begin
        buf0_nxt_s = buf0_r;
        buf1_nxt_s = buf1_r;
        held_nxt_s = held_r + {1'b0, pend_r} - {1'b0, pop_s};
        case ({pend_r, pop_s})
            2'b10: begin
                if (held_r == 2'd0) begin
                    buf0_nxt_s = fifo_rdata;
                end else begin
                    buf1_nxt_s = fifo_rdata;
                end
            end
            2'b11: begin
                if (held_r == 2'd1) begin
                    buf0_nxt_s = fifo_rdata;
                end else begin
                    buf0_nxt_s = buf1_r;
                    buf1_nxt_s = fifo_rdata;
                end
            end
            2'b01: begin
                buf0_nxt_s = buf1_r;
            end
            default: begin
                buf0_nxt_s = buf0_r;
                buf1_nxt_s = buf1_r;
            end
        endcase
    end

    // Burst beat index advances on every accepted beat and wraps at BURST-1.
    always_comb begin
        beat_nxt_s = beat_cnt_r;
        if (pop_s) begin
            beat_nxt_s = (beat_cnt_r == LAST_BEAT) ? 8'd0 : beat_cnt_r + 8'd1;
        end else begin
            beat_nxt_s = beat_cnt_r;
        end
    end

    // State registers; reset discards buffered and in-flight words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r     <= 1'b0;
            held_r     <= 2'd0;
            buf0_r     <= '0;
            buf1_r     <= '0;
            beat_cnt_r <= 8'd0;
        end else begin
            pend_r     <= rinc_s;
            held_r     <= held_nxt_s;
            buf0_r     <= buf0_nxt_s;
            buf1_r     <= buf1_nxt_s;
            beat_cnt_r <= beat_nxt_s;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: directed vector table (BURST=4) plus a randomized
// scoreboard run on a second instance with BURST=3.
module tb_fifo_rd_stream;

    typedef struct {
        logic       en;
        logic       rdy;
        logic       rinc;
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic [1:0] held;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] en = 2'b00;
    logic [1:0] rdy = 2'b00;
    logic [1:0] wr_en = 2'b00;
    logic [7:0] wr_data [2];
    logic [1:0] empty;
    logic [1:0] rinc;
    logic [1:0] valid;
    logic [1:0] last;
    logic [7:0] rdata [2];
    logic [7:0] mdata [2];
    logic [7:0] bcnt [2];
    logic [7:0] wptr [2];
    logic [7:0] rptr [2];
    logic [7:0] mem [2][256];

    vec_t vecs [36];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DSIZE(8), .BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .fifo_empty(empty[0]),
        .fifo_rdata(rdata[0]), .fifo_rinc(rinc[0]), .m_valid(valid[0]),
        .m_ready(rdy[0]), .m_data(mdata[0]), .m_last(last[0]), .beat_cnt(bcnt[0])
    );

    fifo_rd_stream #(.DSIZE(8), .BURST(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .fifo_empty(empty[1]),
        .fifo_rdata(rdata[1]), .fifo_rinc(rinc[1]), .m_valid(valid[1]),
        .m_ready(rdy[1]), .m_data(mdata[1]), .m_last(last[1]), .beat_cnt(bcnt[1])
    );

    // FIFO model per instance: registered read data, empty from registered pointers.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                wptr[i]  <= 8'd0;
                rptr[i]  <= 8'd0;
                rdata[i] <= 8'd0;
            end else begin
                if (wr_en[i]) begin
                    mem[i][wptr[i]] <= wr_data[i];
                    wptr[i] <= wptr[i] + 8'd1;
                end
                if (rinc[i]) begin
                    rdata[i] <= mem[i][rptr[i]];
                    rptr[i]  <= rptr[i] + 8'd1;
                end
            end
        end
    end

    assign empty[0] = (wptr[0] == rptr[0]);
    assign empty[1] = (wptr[1] == rptr[1]);

    function automatic vec_t mk(int e, int r, int ri, int v, int d, int l, int h);
        vec_t x;
        x.en = e[0]; x.rdy = r[0]; x.rinc = ri[0]; x.valid = v[0];
        x.data = d[7:0]; x.last = l[0]; x.held = h[1:0];
        return x;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 2'b00; rdy = 2'b00; wr_en = 2'b00;
        wr_data[0] = 8'd0; wr_data[1] = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic preload(int n, int first);
        for (int k = 0; k < n; k++) begin
            wr_en[0] = 1'b1;
            wr_data[0] = 8'(first + k);
            @(posedge clk);
            #1;
        end
        wr_en[0] = 1'b0;
    endtask

    task automatic run_vecs(int lo, int hi);
        for (int i = lo; i <= hi; i++) begin
            en[0]  = vecs[i].en;
            rdy[0] = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d rinc", i), int'(rinc[0]), int'(vecs[i].rinc));
            chk($sformatf("v%0d valid", i), int'(valid[0]), int'(vecs[i].valid));
            chk($sformatf("v%0d last", i), int'(last[0]), int'(vecs[i].last));
            chk($sformatf("v%0d held", i), int'(dut.held_r), int'(vecs[i].held));
            if (vecs[i].valid) begin
                chk($sformatf("v%0d data", i), int'(mdata[0]), int'(vecs[i].data));
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int sent;
        int got;
        int waited;

        // Streaming, 8 words, m_ready=1: en, rdy, rinc, valid, data, last, held
        vecs[0]  = mk(1, 1, 1, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 1, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 1, 1, 0, 0, 1);
        vecs[3]  = mk(1, 1, 1, 1, 1, 0, 1);
        vecs[4]  = mk(1, 1, 1, 1, 2, 0, 1);
        vecs[5]  = mk(1, 1, 1, 1, 3, 1, 1);
        vecs[6]  = mk(1, 1, 1, 1, 4, 0, 1);
        vecs[7]  = mk(1, 1, 1, 1, 5, 0, 1);
        vecs[8]  = mk(1, 1, 0, 1, 6, 0, 1);
        vecs[9]  = mk(1, 1, 0, 1, 7, 1, 1);
        vecs[10] = mk(1, 1, 0, 0, 0, 0, 0);
        // Backpressure then release
        vecs[11] = mk(1, 0, 1, 0, 0, 0, 0);
        vecs[12] = mk(1, 0, 1, 0, 0, 0, 0);
        vecs[13] = mk(1, 0, 0, 1, 0, 0, 1);
        vecs[14] = mk(1, 0, 0, 1, 0, 0, 2);
        vecs[15] = mk(1, 0, 0, 1, 0, 0, 2);
        vecs[16] = mk(1, 0, 0, 1, 0, 0, 2);
        vecs[17] = mk(1, 1, 1, 1, 0, 0, 2);
        vecs[18] = mk(1, 1, 1, 1, 1, 0, 1);
        vecs[19] = mk(1, 1, 1, 1, 2, 0, 1);
        vecs[20] = mk(1, 1, 1, 1, 3, 1, 1);
        vecs[21] = mk(1, 1, 1, 1, 4, 0, 1);
        vecs[22] = mk(1, 1, 1, 1, 5, 0, 1);
        vecs[23] = mk(1, 1, 0, 1, 6, 0, 1);
        vecs[24] = mk(1, 1, 0, 1, 7, 1, 1);
        vecs[25] = mk(1, 1, 0, 0, 0, 0, 0);
        // Enable gating after the 3rd read, then resume
        vecs[26] = mk(1, 1, 1, 0, 0, 0, 0);
        vecs[27] = mk(1, 1, 1, 0, 0, 0, 0);
        vecs[28] = mk(1, 1, 1, 1, 0, 0, 1);
        vecs[29] = mk(0, 1, 0, 1, 1, 0, 1);
        vecs[30] = mk(0, 1, 0, 1, 2, 0, 1);
        vecs[31] = mk(0, 1, 0, 0, 0, 0, 0);
        vecs[32] = mk(0, 1, 0, 0, 0, 0, 0);
        vecs[33] = mk(1, 1, 1, 0, 0, 0, 0);
        vecs[34] = mk(1, 1, 1, 0, 0, 0, 0);
        vecs[35] = mk(1, 1, 1, 1, 3, 1, 1);

        do_reset();
        @(negedge clk);
        chk("rst valid", int'(valid[0]), 0);
        chk("rst rinc", int'(rinc[0]), 0);
        chk("rst data", int'(mdata[0]), 0);
        chk("rst beat", int'(bcnt[0]), 0);
        @(posedge clk);
        #1;

        // Single word
        preload(1, 8'hA5);
        en[0] = 1'b1; rdy[0] = 1'b1;
        @(negedge clk); chk("one rinc c0", int'(rinc[0]), 1);
        @(posedge clk); #1;
        @(negedge clk); chk("one rinc c1", int'(rinc[0]), 0);
        chk("one valid c1", int'(valid[0]), 0);
        @(posedge clk); #1;
        @(negedge clk); chk("one valid c2", int'(valid[0]), 1);
        chk("one data c2", int'(mdata[0]), 8'hA5);
        chk("one last c2", int'(last[0]), 0);
        chk("one beat c2", int'(bcnt[0]), 0);
        @(posedge clk); #1;
        @(negedge clk); chk("one valid c3", int'(valid[0]), 0);
        chk("one beat c3", int'(bcnt[0]), 1);
        chk("one rinc c3", int'(rinc[0]), 0);

        do_reset(); preload(8, 0); run_vecs(0, 10);
        do_reset(); preload(8, 0); run_vecs(11, 25);
        do_reset(); preload(8, 0); run_vecs(26, 35);

        // Asynchronous reset mid-burst at beat 2
        do_reset(); preload(8, 0);
        en[0] = 1'b1; rdy[0] = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("pre-rst valid", int'(valid[0]), 1);
        chk("pre-rst beat", int'(bcnt[0]), 2);
        rst_n = 1'b0;
        #1;
        chk("mid-rst valid", int'(valid[0]), 0);
        chk("mid-rst last", int'(last[0]), 0);
        chk("mid-rst rinc", int'(rinc[0]), 0);
        chk("mid-rst beat", int'(bcnt[0]), 0);
        en[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        preload(8, 0);
        en[0] = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!valid[0] && waited < 10) begin
            waited++;
            @(negedge clk);
        end
        chk("post-rst valid", int'(valid[0]), 1);
        chk("post-rst beat", int'(bcnt[0]), 0);
        chk("post-rst data", int'(mdata[0]), 0);
        @(posedge clk); #1;

        // Random stress on the BURST=3 instance
        do_reset();
        sent = 0; got = 0;
        en[1] = 1'b1;
        for (int cyc = 0; cyc < 4000 && got < 150; cyc++) begin
            wr_en[1]   = (sent < 150) && ($urandom_range(0, 1) == 1);
            wr_data[1] = 8'(sent);
            rdy[1]     = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            chk("stress rinc while empty", int'(rinc[1] && empty[1]), 0);
            chk("stress held over 2", int'(dut3.held_r == 2'd3), 0);
            if (valid[1] && rdy[1]) begin
                chk("stress data", int'(mdata[1]), got);
                chk("stress last", int'(last[1]), int'((got % 3) == 2));
                got++;
            end
            @(posedge clk);
            if (wr_en[1]) sent++;
            #1;
        end
        chk("stress delivered", got, 150);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side streaming engine for the synchronous FIFO. It drives the FIFO controller's read-increment request from the controller's registered `empty` flag, and captures words from the registered-read FIFO memory. It presents those words downstream on a valid/ready stream with a burst-boundary `m_last` marker. A 2-entry output buffer absorbs the 1-cycle memory read latency so that one beat per cycle is sustained under continuous `m_ready`.

## Interface
- `DSIZE`, default 8: data word width.
- `BURST`, default 4: beats per burst; `m_last` marks every BURST-th beat; legal range 1..256.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `en`  in  1  permits new FIFO reads; in-flight and buffered data still drain when low.
- `fifo_empty`  in  1  registered empty flag from the FIFO controller.
- `fifo_rdata`  in  DSIZE  FIFO memory read data; valid in the cycle after an accepted `fifo_rinc`.
- `fifo_rinc`  out  1  read-increment request to the FIFO controller.
- `m_valid`  out  1  output word available.
- `m_ready`  in  1  downstream accepts the word.
- `m_data`  out  DSIZE  output word, head of the buffer.
- `m_last`  out  1  current beat is the last of a burst.
- `beat_cnt`  out  8  index of the current beat within its burst, 0..BURST-1.

## Operation
- State:
  - `pend`: 1 bit, a read was issued last cycle.
  - 2-entry buffer (`buf0` is head, `buf1`) with `held`, 2 bits, value 0..2.
  - `beat_cnt`.
- Definitions:
  - `pop = m_valid && m_ready`
  - `total = held + pend`, 2-bit arithmetic, never exceeds 2.
- `fifo_rinc = en && !fifo_empty && (total < 2 || (total == 2 && pop))`.
  - This is combinational from registered state plus `m_ready`.
  - `fifo_rinc` is never asserted while `fifo_empty` = 1, so the block does not rely on simultaneous-write pass-through.
- `pend <= fifo_rinc` each cycle.
- Capture: when `pend` = 1, `fifo_rdata` is written into the buffer at the edge.
  - If no pop: it goes to `buf0` when `held` = 0, else to `buf1`.
  - If pop with `held` = 1: it goes to `buf0`.
  - If pop with `held` = 2: `buf1` shifts to `buf0` and the new word goes to `buf1`.
- Pop without capture: `buf1` shifts to `buf0` and `held` decrements.
- `held` update: `held_next = held + pend - pop`. It never goes above 2 or below 0; the bench asserts this.
- `m_valid = (held != 0)`. `m_data = buf0`.
- While `m_valid && !m_ready`, `m_data`, `m_last` and `beat_cnt` hold stable.
- Burst counter: on each pop, `beat_cnt <= (beat_cnt == BURST-1) ? 0 : beat_cnt + 1`.
  - `m_last = m_valid && (beat_cnt == BURST-1)`.
  - With BURST = 1, `m_last` = `m_valid`.
- Deasserting `en` blocks new reads only. Words already in flight are still captured and delivered; no word is dropped or duplicated.

## Timing
- Reset values (while `rst_n` = 0):
  - `pend`, `held`, `buf0`, `buf1`, `beat_cnt` are all 0.
  - Outputs: `m_valid` = 0, `m_last` = 0, `m_data` = 0, `fifo_rinc` = 0 (`fifo_rinc` is forced 0 combinationally during reset).
- Reset is asynchronous. Asserting it mid-burst discards buffered and in-flight words and clears `beat_cnt`.
  - The FIFO controller shares the same reset, so its pointers are cleared in the same event.
- Latency: `fifo_rinc` high in cycle N, `fifo_rdata` valid in N+1, captured at the end of N+1, `m_valid` high in N+2.
- Throughput: 1 beat per cycle while `m_ready` = 1 and the FIFO stays non-empty.
- Backpressure:
  - With `m_ready` held low, at most 2 reads are outstanding, then `fifo_rinc` stays 0.
  - When `m_ready` rises, `fifo_rinc` reasserts in that same cycle (via the `total == 2 && pop` term).
- `fifo_empty` rises after the last word is read: the block issues no further `fifo_rinc` and the buffer drains normally.

## Test plan
- Reset: assert `rst_n` = 0 mid-stream with `m_valid` = 1 and `beat_cnt` = 2 -> immediately `m_valid` = 0, `m_last` = 0, `fifo_rinc` = 0, `beat_cnt` = 0. After release, the first beat again has `beat_cnt` = 0.
- Single word: FIFO holds 0xA5, `en` = 1, `m_ready` = 1 -> `fifo_rinc` pulses in cycle 0. `m_valid` = 1 with `m_data` = 0xA5 in cycle 2, `m_last` = 0. `beat_cnt` = 1 afterwards. No further `fifo_rinc`.
- Streaming: 8 words 0x00..0x07 preloaded, `m_ready` = 1 -> 8 consecutive `m_valid` cycles carrying 0x00..0x07 in order. `m_last` = 1 on 0x03 and 0x07 only.
- Backpressure: 8 words preloaded, `m_ready` = 0 -> exactly 2 `fifo_rinc` pulses. `m_data` = 0x00 held stable, `held` = 2. Raise `m_ready` -> `fifo_rinc` reasserts in the same cycle and 0x00..0x07 are delivered with no loss or duplication.
- Enable gating: drop `en` right after the 3rd `fifo_rinc` with `m_ready` = 1 -> exactly 3 words (0x00..0x02) are delivered, then `m_valid` = 0. Re-raise `en` -> delivery resumes at 0x03.
- Random stress: random `m_ready`, random FIFO writes, BURST = 3 -> a scoreboard confirms in-order, lossless delivery. `m_last` falls on every 3rd beat. `held` ≤ 2 is asserted and `fifo_rinc` is never high while `fifo_empty` = 1.
